// File: rtl/fb_arbiter_pkg.sv
// Shared definitions for the framebuffer SRAM arbiter.
//   FB_AW            default SRAM byte-address width
//   FB_STALL_LIMIT   default PENDING clocks without vga_idle before a forced slot
//   fb_state_t       request buffer state encoding
package fb_arbiter_pkg;

    localparam int unsigned FB_AW          = 21;
    localparam int unsigned FB_STALL_LIMIT = 15;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PENDING = 1'b1
    } fb_state_t;

endpackage : fb_arbiter_pkg

// File: rtl/fb_arbiter_if.sv
// CPU request/response channel of the framebuffer arbiter.
//   cpu_valid/cpu_ready  request handshake, accepted on valid & ready
//   cpu_we/addr/wdata    request payload, sampled at accept
//   cpu_rdata            read result, holds until the next read completes
//   cpu_rvalid           one-clock pulse when cpu_rdata is updated
// Modports: master = CPU side, slave = arbiter side.
interface fb_arbiter_if
    import fb_arbiter_pkg::*;
#(
    parameter int unsigned AW = FB_AW
);
    logic          cpu_valid;
    logic          cpu_ready;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_rvalid;

    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_rvalid
    );

    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_rvalid
    );
endinterface : fb_arbiter_if

// File: rtl/fb_req_buf.sv
// One-entry CPU request buffer plus stall watchdog.
//   clk, reset           clock, synchronous active-high reset
//   cpu_valid/cpu_ready  request handshake (ready = buffer empty)
//   cpu_we/addr/wdata    request payload, latched at accept
//   vga_idle             scan-out slot strobe
//   slot                 the current clock is the CPU's bus slot
//   req_we/addr/wdata    held request, drives the bus mux during the slot
module fb_req_buf
    import fb_arbiter_pkg::*;
#(
    parameter int unsigned AW          = FB_AW,
    parameter int unsigned STALL_LIMIT = FB_STALL_LIMIT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_valid,
    output logic          cpu_ready,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          vga_idle,
    output logic          slot,
    output logic          req_we,
    output logic [AW-1:0] req_addr,
    output logic [7:0]    req_wdata
);

    localparam int unsigned SW = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

    fb_state_t     state;
    logic [SW-1:0] stall;

    assign cpu_ready = (state == ST_EMPTY);

    // Forced slot lands on the clock the counter sits at its limit,
    // i.e. the (STALL_LIMIT+1)th PENDING clock.
    assign slot = (state == ST_PENDING) && (vga_idle || (stall == STALL_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            stall     <= '0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    stall <= '0;
                    if (cpu_valid) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        state     <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (slot) begin
                        stall <= '0;
                        state <= ST_EMPTY;
                    end else if (stall != STALL_MAX) begin
                        stall <= stall + SW'(1);
                    end
                end
                default: begin
                    stall <= '0;
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule : fb_req_buf

// File: rtl/fb_arbiter.sv
// Framebuffer SRAM arbiter: scan-out reads own the bus except during the
// CPU slot (vga_idle clock, or a watchdog-forced clock).
//   clk, reset        clock, synchronous active-high reset
//   vga_addr/vga_rd   scan-out address / read data (zero-latency pass-through)
//   vga_idle          scan-out slot strobe
//   cpu               CPU request channel (fb_arbiter_if.slave)
//   sram_*            asynchronous SRAM pins; d_oe enables the data driver
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int unsigned AW          = FB_AW,
    parameter int unsigned STALL_LIMIT = FB_STALL_LIMIT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] vga_addr,
    output logic [7:0]    vga_rd,
    input  logic          vga_idle,
    fb_arbiter_if.slave   cpu,
    output logic [AW-1:0] sram_a,
    output logic [7:0]    sram_d_o,
    output logic          sram_d_oe,
    input  logic [7:0]    sram_d_i,
    output logic          sram_we_n,
    output logic          sram_oe_n
);

    logic          slot;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_wdata;

    fb_req_buf #(
        .AW          (AW),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_req_buf (
        .clk       (clk),
        .reset     (reset),
        .cpu_valid (cpu.cpu_valid),
        .cpu_ready (cpu.cpu_ready),
        .cpu_we    (cpu.cpu_we),
        .cpu_addr  (cpu.cpu_addr),
        .cpu_wdata (cpu.cpu_wdata),
        .vga_idle  (vga_idle),
        .slot      (slot),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata)
    );

    assign vga_rd = sram_d_i;

    // Every bus output derives from registers (plus the registered vga_idle),
    // so the write strobe is a clean single-clock pulse with stable a/d.
    always_comb begin
        sram_a    = vga_addr;
        sram_d_o  = req_wdata;
        sram_d_oe = 1'b0;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b0;
        if (slot) begin
            sram_a = req_addr;
            if (req_we) begin
                sram_oe_n = 1'b1;
                sram_d_oe = 1'b1;
                sram_we_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu.cpu_rvalid <= 1'b0;
            cpu.cpu_rdata  <= '0;
        end else begin
            cpu.cpu_rvalid <= slot && !req_we;
            if (slot && !req_we) begin
                cpu.cpu_rdata <= sram_d_i;
            end
        end
    end

endmodule : fb_arbiter

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter with a small asynchronous SRAM model
// (byte[a] = a[7:0] at start) and read/write scoreboards.
module tb_fb_arbiter;
    import fb_arbiter_pkg::*;

    localparam int unsigned AW = FB_AW;
    localparam int unsigned SL = FB_STALL_LIMIT;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic [AW-1:0] vga_addr = '0;
    logic [7:0]    vga_rd;
    logic          vga_idle = 1'b0;
    logic [AW-1:0] sram_a;
    logic [7:0]    sram_d_o;
    logic          sram_d_oe;
    logic [7:0]    sram_d_i;
    logic          sram_we_n;
    logic          sram_oe_n;

    fb_arbiter_if #(.AW(AW)) cpu_if ();

    fb_arbiter #(
        .AW          (AW),
        .STALL_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vga_addr  (vga_addr),
        .vga_rd    (vga_rd),
        .vga_idle  (vga_idle),
        .cpu       (cpu_if),
        .sram_a    (sram_a),
        .sram_d_o  (sram_d_o),
        .sram_d_oe (sram_d_oe),
        .sram_d_i  (sram_d_i),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: asynchronous read, write on the clock edge ending a we_n-low clock
    logic [7:0] mem     [0:4095];
    logic [7:0] exp_mem [0:4095];
    assign sram_d_i = mem[sram_a[11:0]];
    always @(posedge clk) if (!sram_we_n) mem[sram_a[11:0]] <= sram_d_o;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;
    wr_t        wr_q [$];
    logic [7:0] rd_q [$];

    // vga_idle: one clock high in every 5
    logic        idle_en = 1'b1;
    int unsigned ph      = 0;
    initial forever begin
        @(posedge clk);
        #1;
        ph       = (ph == 4) ? 0 : ph + 1;
        vga_idle = idle_en && (ph == 4);
    end

    // Scoreboard monitors
    always @(negedge clk) begin : mon
        wr_t        w;
        logic [7:0] r;
        if (!reset) begin
            if (!sram_we_n) begin
                if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    w = wr_q.pop_front();
                    check("wr_addr", sram_a, w.a);
                    check("wr_data", sram_d_o, w.d);
                    check("wr_oe_n", sram_oe_n, 1);
                    check("wr_d_oe", sram_d_oe, 1);
                end
            end
            if (cpu_if.cpu_rvalid) begin
                if (rd_q.size() == 0) check("rvalid_unexpected", 1, 0);
                else begin
                    r = rd_q.pop_front();
                    check("rd_data", cpu_if.cpu_rdata, r);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a request; push the expectation at the negedge before the accepting edge.
    int unsigned acc_cyc;
    task automatic req(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        wr_t w;
        cpu_if.cpu_valid = 1'b1;
        cpu_if.cpu_we    = we;
        cpu_if.cpu_addr  = a;
        cpu_if.cpu_wdata = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu_if.cpu_ready) begin
                if (we) begin
                    w.a = a; w.d = d;
                    wr_q.push_back(w);
                    exp_mem[a[11:0]] = d;
                end else begin
                    rd_q.push_back(exp_mem[a[11:0]]);
                end
                acc_cyc = cyc;
                tick();
                cpu_if.cpu_valid = 1'b0;
                return;
            end
            tick();
        end
        check("accept_timeout", 0, 1);
        cpu_if.cpu_valid = 1'b0;
    endtask

    task automatic wait_ph1();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ph == 1) break;
        end
        tick();
    endtask

    task automatic count_forced(input string tag);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (!sram_we_n) break;
        end
        check(tag, n, SL + 1);
        @(negedge clk);
        check({tag, "_we_pulse"}, sram_we_n, 1);
        check({tag, "_ready"}, cpu_if.cpu_ready, 1);
    endtask

    initial begin
        automatic logic [AW-1:0] ba [3] = '{21'h00100, 21'h00101, 21'h00102};
        automatic logic [7:0]    bd [3] = '{8'h11, 8'h22, 8'h33};
        int unsigned acc [3];
        int unsigned k;

        for (int i = 0; i < 4096; i++) begin
            mem[i]     = i[7:0];
            exp_mem[i] = i[7:0];
        end
        cpu_if.cpu_valid = 1'b0;
        cpu_if.cpu_we    = 1'b0;
        cpu_if.cpu_addr  = '0;
        cpu_if.cpu_wdata = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", cpu_if.cpu_ready, 1);
        check("rst_rvalid", cpu_if.cpu_rvalid, 0);
        check("rst_rdata", cpu_if.cpu_rdata, 0);
        tick();
        reset    = 1'b0;
        vga_addr = 21'h00123;

        // Idle traffic only
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", cpu_if.cpu_ready, 1);
            check("idle_rvalid", cpu_if.cpu_rvalid, 0);
            check("idle_we_n", sram_we_n, 1);
        end
        check("vga_rd", vga_rd, 8'h23);
        check("vga_sram_a", sram_a, 21'h00123);
        check("vga_oe_n", sram_oe_n, 0);

        // Write accepted two clocks before idle
        wait_ph1();
        req(1'b1, 21'h00040, 8'hA5);
        @(negedge clk);
        check("w_clk1_ready", cpu_if.cpu_ready, 0);
        check("w_clk1_we_n", sram_we_n, 1);
        @(negedge clk);
        check("w_slot_idle", vga_idle, 1);
        check("w_slot_ready", cpu_if.cpu_ready, 0);
        check("w_slot_a", sram_a, 21'h00040);
        check("w_slot_we_n", sram_we_n, 0);
        check("w_slot_d_o", sram_d_o, 8'hA5);
        @(negedge clk);
        check("w_after_ready", cpu_if.cpu_ready, 1);
        check("w_after_we_n", sram_we_n, 1);
        check("w_mem40", mem[12'h040], 8'hA5);

        // Read of the same byte
        wait_ph1();
        req(1'b0, 21'h00040, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("r_slot_a", sram_a, 21'h00040);
        check("r_slot_oe_n", sram_oe_n, 0);
        check("r_slot_we_n", sram_we_n, 1);
        @(negedge clk);
        check("r_rvalid", cpu_if.cpu_rvalid, 1);
        check("r_rdata", cpu_if.cpu_rdata, 8'hA5);
        @(negedge clk);
        check("r_rvalid_pulse", cpu_if.cpu_rvalid, 0);
        check("r_rdata_hold", cpu_if.cpu_rdata, 8'hA5);
        tick();

        // Watchdog-forced slot with idle held low
        idle_en = 1'b0;
        repeat (2) tick();
        req(1'b1, 21'h00055, 8'h3C);
        count_forced("forced");
        check("forced_mem55", mem[12'h055], 8'h3C);

        // Back-to-back writes with cpu_valid held high
        idle_en = 1'b1;
        repeat (6) tick();
        k = 0;
        cpu_if.cpu_valid = 1'b1;
        cpu_if.cpu_we    = 1'b1;
        cpu_if.cpu_addr  = ba[0];
        cpu_if.cpu_wdata = bd[0];
        for (int i = 0; i < 100 && k < 3; i++) begin
            @(negedge clk);
            if (cpu_if.cpu_ready) begin
                wr_q.push_back('{a: ba[k], d: bd[k]});
                exp_mem[ba[k][11:0]] = bd[k];
                acc[k] = cyc;
                k++;
                tick();
                if (k < 3) begin
                    cpu_if.cpu_addr  = ba[k];
                    cpu_if.cpu_wdata = bd[k];
                end else begin
                    cpu_if.cpu_valid = 1'b0;
                end
            end else begin
                tick();
            end
        end
        check("b2b_accepts", k, 3);
        check("b2b_spacing", acc[2] - acc[1], 5);
        repeat (8) tick();
        check("b2b_mem100", mem[12'h100], 8'h11);
        check("b2b_mem101", mem[12'h101], 8'h22);
        check("b2b_mem102", mem[12'h102], 8'h33);

        // Reset while a read is pending
        idle_en = 1'b0;
        repeat (2) tick();
        req(1'b0, 21'h00040, 8'h00);
        repeat (3) tick();
        reset = 1'b1;
        rd_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_bus_a", sram_a, vga_addr);
            check("rst_bus_we_n", sram_we_n, 1);
            check("rst_bus_rvalid", cpu_if.cpu_rvalid, 0);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", cpu_if.cpu_ready, 1);
        check("post_rst_rvalid", cpu_if.cpu_rvalid, 0);
        tick();
        // A fresh forced slot must again take the full count
        req(1'b1, 21'h00077, 8'h5A);
        count_forced("post_rst_forced");

        idle_en = 1'b1;
        repeat (12) tick();
        check("wr_q_drained", wr_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_fb_arbiter
